// File: rtl/ip2_pkg.sv
// Shared types and constants for the IP2 test scheduler.
// Holds FSM encoding, pin bundle and idle pin levels.
package ip2_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_START  = 2'b01,
    S_RUN    = 2'b10,
    S_FINISH = 2'b11
  } sched_state_e;

  localparam logic RESET_NOT_IDLE = 1'b1;
  localparam logic SCAN_LOAD_IDLE = 1'b1;

  typedef struct packed {
    logic reset_not;
    logic scan_in;
    logic scan_load;
    logic config_clk;
    logic config_in;
    logic config_load;
  } pins_t;

  localparam pins_t PINS_IDLE = '{
    reset_not:   RESET_NOT_IDLE,
    scan_in:     1'b0,
    scan_load:   SCAN_LOAD_IDLE,
    config_clk:  1'b0,
    config_in:   1'b0,
    config_load: 1'b0
  };

  function automatic logic pick(input logic [7:0] v,
                                input logic [2:0] i);
    return v[i];
  endfunction

endpackage

// File: rtl/ip2_edge_det.sv
// Rising-edge detector for one test_req level.
// Output is combinational: level high, previous sample low.
module ip2_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // next previous-sample value
  always_comb prev_d = d;

  // previous-sample register
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/ip2_test_sched.sv
// IP2 test scheduler: queues test requests, runs one at a time,
// muxes its pins to the ASIC and guards each run with a watchdog.
module ip2_test_sched
  import ip2_pkg::*;
#(
  parameter int NTEST = 4,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [NTEST-1:0] test_req,
  input  logic [5:0]       clk_period_max,
  input  logic [TO_W-1:0]  timeout_max,
  input  logic [NTEST-1:0] test_done,
  input  logic [NTEST-1:0] test_reset_not,
  input  logic [NTEST-1:0] test_scan_in,
  input  logic [NTEST-1:0] test_scan_load,
  input  logic [NTEST-1:0] test_config_clk,
  input  logic [NTEST-1:0] test_config_in,
  input  logic [NTEST-1:0] test_config_load,
  output logic [5:0]       clk_counter,
  output logic [NTEST-1:0] test_enable_re,
  output logic [NTEST-1:0] test_enable,
  output logic             o_reset_not,
  output logic             o_scan_in,
  output logic             o_scan_load,
  output logic             o_config_clk,
  output logic             o_config_in,
  output logic             o_config_load,
  output logic             busy,
  output logic [2:0]       grant_idx,
  output logic             done,
  output logic             timeout_err,
  output logic [1:0]       sched_state
);

  logic rst;
  assign rst = reset | ~enable;

  logic [NTEST-1:0] req_re;

  for (genvar g = 0; g < NTEST; g++) begin : g_edge
    ip2_edge_det u_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (test_req[g]),
      .rise (req_re[g])
    );
  end

  logic [5:0] cnt_q, cnt_d, per_q, per_d, per_eff;

  // phase counter; new terminal value is picked up at count 0
  always_comb begin
    per_eff = (cnt_q == 6'd0) ? clk_period_max : per_q;
    per_d   = per_eff;
    cnt_d   = (cnt_q >= per_eff) ? 6'd0 : cnt_q + 6'd1;
  end

  // phase counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

  sched_state_e     state_q, state_d;
  logic [2:0]       grant_q, grant_d, low_idx;
  logic [NTEST-1:0] pend_q, pend_d, re_q, re_d, ten_q, ten_d;
  logic             done_q, done_d, tmo_q, tmo_d;
  logic             dprev_q, dprev_d, done_g;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic [7:0]       sel_low, sel_grant;
  pins_t            pins_q, pins_d;

  // scheduler next state, watchdog and pin mux
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    pend_d  = pend_q | req_re;
    done_d  = done_q;
    tmo_d   = tmo_q;
    wd_d    = wd_q;
    re_d    = '0;
    ten_d   = '1;
    low_idx = '0;
    for (int i = NTEST - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = 3'(i);
    end
    sel_low   = 8'd1 << low_idx;
    sel_grant = 8'd1 << grant_q;
    done_g    = pick(8'(test_done), grant_q);
    dprev_d   = done_g;
    unique case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          grant_d = low_idx;
          pend_d  = (pend_q & ~sel_low[NTEST-1:0]) | req_re;
          re_d    = sel_low[NTEST-1:0];
          state_d = S_START;
        end
      end
      S_START: begin
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (done_g && !dprev_q) begin
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else if (timeout_max != '0 && wd_q == timeout_max) begin
          tmo_d   = 1'b1;
          ten_d   = ~sel_grant[NTEST-1:0];
          state_d = S_FINISH;
        end else if (wd_q != {TO_W{1'b1}}) begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_FINISH: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      pins_d = PINS_IDLE;
    end else begin
      pins_d.reset_not   = pick(8'(test_reset_not), grant_d);
      pins_d.scan_in     = pick(8'(test_scan_in), grant_d);
      pins_d.scan_load   = pick(8'(test_scan_load), grant_d);
      pins_d.config_clk  = pick(8'(test_config_clk), grant_d);
      pins_d.config_in   = pick(8'(test_config_in), grant_d);
      pins_d.config_load = pick(8'(test_config_load), grant_d);
    end
  end

  // scheduler registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      pend_q  <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      wd_q    <= '0;
      re_q    <= '0;
      ten_q   <= '1;
      dprev_q <= 1'b0;
      pins_q  <= PINS_IDLE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      wd_q    <= wd_d;
      re_q    <= re_d;
      ten_q   <= ten_d;
      dprev_q <= dprev_d;
      pins_q  <= pins_d;
    end
  end

  assign clk_counter    = cnt_q;
  assign test_enable_re = re_q;
  assign test_enable    = ten_q;
  assign o_reset_not    = pins_q.reset_not;
  assign o_scan_in      = pins_q.scan_in;
  assign o_scan_load    = pins_q.scan_load;
  assign o_config_clk   = pins_q.config_clk;
  assign o_config_in    = pins_q.config_in;
  assign o_config_load  = pins_q.config_load;
  assign busy           = (state_q != S_IDLE);
  assign grant_idx      = grant_q;
  assign done           = done_q;
  assign timeout_err    = tmo_q;
  assign sched_state    = state_q;

endmodule
